// File: rtl/pwm_array_gen.sv
// pwm_array_gen: N_CH complementary PWM channels behind a small register bus.
// All channels share one prescaler and one period counter (edge or center
// aligned). PERIOD/CENTER/DUTY/DEADTIME are shadowed and only take effect at
// the period boundary, when period_evt_o pulses.
// Optional feature macro: PWM_DEADTIME_EN (per-channel dead-time insertion).
module pwm_array_gen #(
   parameter int N_CH  = 8,
   parameter int CNT_W = 16,
   parameter int PSC_W = 8,
   parameter int DT_W  = 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [7:0]       addr_i,
   input  logic             wr_en_i,
   input  logic             rd_en_i,
   input  logic [15:0]      wdata_i,
   output logic [15:0]      rdata_o,
   output logic [N_CH-1:0]  pwm_a_o,
   output logic [N_CH-1:0]  pwm_b_o,
   output logic             period_evt_o
);

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   localparam logic [7:0] ADDR_CTRL   = 8'h00;
   localparam logic [7:0] ADDR_PSC    = 8'h01;
   localparam logic [7:0] ADDR_PERIOD = 8'h02;
   localparam logic [7:0] ADDR_DT     = 8'h03;
   localparam logic [7:0] ADDR_MASK   = 8'h04;
   localparam logic [7:0] ADDR_STATUS = 8'h05;
   localparam logic [7:0] ADDR_DUTY   = 8'h10;

   logic              en_sh;
   logic              center_sh;
   logic [PSC_W-1:0]  psc_sh;
   logic [CNT_W-1:0]  period_sh;
   logic [DT_W-1:0]   dt_sh;
   logic [N_CH-1:0]   mask_sh;
   logic [CNT_W-1:0]  duty_sh [N_CH];

   logic              center_act;
   logic [CNT_W-1:0]  period_act;
   logic [CNT_W-1:0]  duty_act [N_CH];

   logic [PSC_W-1:0]  psc_cnt;
   logic [CNT_W-1:0]  cnt;
   dir_t              dir;

   logic              tick;
   logic              update_evt;
   logic              load_act;
   logic [CNT_W-1:0]  cnt_nxt;
   dir_t              dir_nxt;
   logic [N_CH-1:0]   raw;
   logic [N_CH-1:0]   gate;
   logic [15:0]       rd_mux;

   // Bus writes land in the shadow registers, truncated to each field's width.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         en_sh     <= 1'b0;
         center_sh <= 1'b0;
         psc_sh    <= '0;
         period_sh <= '0;
         mask_sh   <= '0;
         for (int k = 0; k < N_CH; k++) begin
            duty_sh[k] <= '0;
         end
      end else if (wr_en_i) begin
         case (addr_i)
            ADDR_CTRL: begin
               en_sh     <= wdata_i[0];
               center_sh <= wdata_i[1];
            end
            ADDR_PSC:    psc_sh    <= wdata_i[PSC_W-1:0];
            ADDR_PERIOD: period_sh <= wdata_i[CNT_W-1:0];
            ADDR_MASK:   mask_sh   <= wdata_i[N_CH-1:0];
            default: ;
         endcase
         for (int k = 0; k < N_CH; k++) begin
            if (addr_i == ADDR_DUTY + 8'(k)) begin
               duty_sh[k] <= wdata_i[CNT_W-1:0];
            end
         end
      end
   end

`ifdef PWM_DEADTIME_EN
   // The dead-time shadow register only exists when dead-time is built in.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         dt_sh <= '0;
      end else if (wr_en_i && addr_i == ADDR_DT) begin
         dt_sh <= wdata_i[DT_W-1:0];
      end
   end
`else
   assign dt_sh = '0;
`endif

   // Next counter value and direction for the coming tick; a prescaler count
   // at or beyond PSC also ticks so a lowered PSC never stalls the counter.
   always_comb begin
      tick    = (psc_cnt >= psc_sh);
      cnt_nxt = cnt;
      dir_nxt = dir;
      if (period_act == '0) begin
         cnt_nxt = '0;
         dir_nxt = DIR_UP;
      end else if (!center_act) begin
         cnt_nxt = (cnt >= period_act) ? '0 : cnt + 1'b1;
         dir_nxt = DIR_UP;
      end else begin
         if (dir == DIR_UP) begin
            cnt_nxt = (cnt >= period_act) ? period_act - 1'b1 : cnt + 1'b1;
         end else begin
            cnt_nxt = (cnt == '0) ? CNT_W'(1) : cnt - 1'b1;
         end
         if (cnt_nxt == period_act) begin
            dir_nxt = DIR_DOWN;
         end else if (cnt_nxt == '0) begin
            dir_nxt = DIR_UP;
         end
      end
      update_evt = en_sh && tick && (cnt_nxt == '0);
      load_act   = !en_sh || update_evt;
   end

   // Prescaler, period counter and event strobe; everything parks at zero
   // while disabled so re-enabling always starts a fresh period.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         psc_cnt      <= '0;
         cnt          <= '0;
         dir          <= DIR_UP;
         period_evt_o <= 1'b0;
      end else if (!en_sh) begin
         psc_cnt      <= '0;
         cnt          <= '0;
         dir          <= DIR_UP;
         period_evt_o <= 1'b0;
      end else begin
         period_evt_o <= update_evt;
         if (tick) begin
            psc_cnt <= '0;
            cnt     <= cnt_nxt;
            dir     <= dir_nxt;
         end else begin
            psc_cnt <= psc_cnt + 1'b1;
         end
      end
   end

   // Active registers follow the shadows while disabled and otherwise only
   // at the update event, so a period never runs with mixed settings.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         center_act <= 1'b0;
         period_act <= '0;
         for (int k = 0; k < N_CH; k++) begin
            duty_act[k] <= '0;
         end
      end else if (load_act) begin
         center_act <= center_sh;
         period_act <= period_sh;
         for (int k = 0; k < N_CH; k++) begin
            duty_act[k] <= duty_sh[k];
         end
      end
   end

   // Per-channel compare; DUTY above PERIOD naturally yields a constant high.
   always_comb begin
      gate = {N_CH{en_sh}} & mask_sh;
      for (int k = 0; k < N_CH; k++) begin
         raw[k] = (cnt < duty_act[k]);
      end
   end

`ifdef PWM_DEADTIME_EN
   logic [DT_W-1:0]  dt_act;
   logic [N_CH-1:0]  raw_q;
   logic [DT_W-1:0]  dt_cnt [N_CH];
   logic [DT_W-1:0]  dt_nxt [N_CH];
   logic [N_CH-1:0]  settled;

   // The active dead-time shares the same load point as the other actives.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         dt_act <= '0;
      end else if (load_act) begin
         dt_act <= dt_sh;
      end
   end

   // Any raw edge restarts the channel's delay; an output may only turn on
   // once the delay has fully run out, so a and b can never overlap.
   always_comb begin
      for (int k = 0; k < N_CH; k++) begin
         if (raw[k] != raw_q[k]) begin
            dt_nxt[k] = dt_act;
         end else if (dt_cnt[k] != '0) begin
            dt_nxt[k] = dt_cnt[k] - 1'b1;
         end else begin
            dt_nxt[k] = '0;
         end
         settled[k] = (dt_nxt[k] == '0);
      end
   end

   // Registered outputs with dead-time applied to the turning-on side.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         raw_q   <= '0;
         pwm_a_o <= '0;
         pwm_b_o <= '0;
         for (int k = 0; k < N_CH; k++) begin
            dt_cnt[k] <= '0;
         end
      end else begin
         raw_q   <= raw;
         pwm_a_o <= gate & raw & settled;
         pwm_b_o <= gate & ~raw & settled;
         for (int k = 0; k < N_CH; k++) begin
            dt_cnt[k] <= dt_nxt[k];
         end
      end
   end
`else
   // Registered complementary outputs, forced off when disabled or masked.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pwm_a_o <= '0;
         pwm_b_o <= '0;
      end else begin
         pwm_a_o <= gate & raw;
         pwm_b_o <= gate & ~raw;
      end
   end
`endif

   // Read decode; STATUS carries the direction in bit 15 over the count.
   always_comb begin
      rd_mux = '0;
      case (addr_i)
         ADDR_CTRL:   rd_mux = {14'b0, center_sh, en_sh};
         ADDR_PSC:    rd_mux = 16'(psc_sh);
         ADDR_PERIOD: rd_mux = 16'(period_sh);
         ADDR_DT:     rd_mux = 16'(dt_sh);
         ADDR_MASK:   rd_mux = 16'(mask_sh);
         ADDR_STATUS: begin
            rd_mux     = 16'(cnt);
            rd_mux[15] = (dir == DIR_DOWN);
         end
         default: ;
      endcase
      for (int k = 0; k < N_CH; k++) begin
         if (addr_i == ADDR_DUTY + 8'(k)) begin
            rd_mux = 16'(duty_sh[k]);
         end
      end
   end

   // Read data is captured on a read strobe and held until the next read.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rdata_o <= '0;
      end else if (rd_en_i) begin
         rdata_o <= rd_mux;
      end
   end

endmodule

// File: tb/tb_pwm_array_gen.sv
// tb_pwm_array_gen: directed and randomized sessions against a closed-form
// model of the PWM array (counter value derived from elapsed clocks).
`timescale 1ns/1ps
module tb_pwm_array_gen;

   localparam int NCH   = 8;
   localparam int NEVER = 1000000;

   logic             clk_i = 1'b0;
   logic             rst_n_i = 1'b0;
   logic [7:0]       addr_i = '0;
   logic             wr_en_i = 1'b0;
   logic             rd_en_i = 1'b0;
   logic [15:0]      wdata_i = '0;
   logic [15:0]      rdata_o;
   logic [NCH-1:0]   pwm_a_o;
   logic [NCH-1:0]   pwm_b_o;
   logic             period_evt_o;

   int vectors = 0;
   int miscompares = 0;
   int k = 0;

   int sPsc, sPer, sCenter, sDt, sKw, sKwCh, sKm;
   logic [NCH-1:0] sMask, sMaskNew;
   int sDutyOld [NCH];
   int sDutyNew [NCH];

   pwm_array_gen #(
      .N_CH(NCH), .CNT_W(16), .PSC_W(8), .DT_W(8)
   ) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .addr_i(addr_i),
      .wr_en_i(wr_en_i), .rd_en_i(rd_en_i), .wdata_i(wdata_i),
      .rdata_o(rdata_o), .pwm_a_o(pwm_a_o), .pwm_b_o(pwm_b_o),
      .period_evt_o(period_evt_o)
   );

   // Free-running 100 MHz clock.
   always #5 clk_i = ~clk_i;

   // Length of one full PWM period in ticks.
   function automatic int perLen();
      if (sPer == 0) return 1;
      return (sCenter != 0) ? 2 * sPer : sPer + 1;
   endfunction

   // Counter value after t ticks into the session.
   function automatic int cntAtTicks(int t);
      int ph;
      if (sPer == 0) return 0;
      ph = t % perLen();
      if (sCenter != 0 && ph > sPer) return 2 * sPer - ph;
      return ph;
   endfunction

   // Direction after t ticks: down from arrival at PERIOD until arrival at 0.
   function automatic bit downAtTicks(int t);
      if (sCenter == 0 || sPer == 0) return 1'b0;
      return (t % perLen()) >= sPer;
   endfunction

   // Compare result seen in the cycle after edge c of the session.
   function automatic bit rawAt(int ch, int c);
      int cc, t, jb, duty;
      cc   = (c < 0) ? 0 : c;
      t    = cc / (sPsc + 1);
      jb   = (sPsc + 1) * perLen() * (t / perLen());
      duty = (jb >= 1 && jb > sKw) ? sDutyNew[ch] : sDutyOld[ch];
      return cntAtTicks(t) < duty;
   endfunction

   // Expected outputs after edge kk: raw must have been stable for DT+1 cycles.
   function automatic void expOut(input int kk, output logic [NCH-1:0] ea,
                                  output logic [NCH-1:0] eb);
      int c;
      logic [NCH-1:0] m;
      bit r, stable;
      c  = kk - 1;
      m  = (c >= sKm) ? sMaskNew : sMask;
      ea = '0;
      eb = '0;
      for (int ch = 0; ch < NCH; ch++) begin
         r = rawAt(ch, c);
         stable = 1'b1;
         for (int d = 1; d <= sDt; d++) begin
            if (rawAt(ch, c - d) != r) stable = 1'b0;
         end
         ea[ch] = m[ch] & r & stable;
         eb[ch] = m[ch] & ~r & stable;
      end
   endfunction

   // An event follows every tick that lands on the start of a period.
   function automatic logic expEvt(int kk);
      if (kk < 1 || (kk % (sPsc + 1)) != 0) return 1'b0;
      return ((kk / (sPsc + 1)) % perLen()) == 0;
   endfunction

   // STATUS as seen after edge c.
   function automatic logic [15:0] expStatus(int c);
      int t;
      logic [15:0] s;
      t = c / (sPsc + 1);
      s = 16'(cntAtTicks(t));
      s[15] = downAtTicks(t);
      return s;
   endfunction

   // Drive one cycle's worth of bus inputs.
   task automatic applyStimulus(input logic wr, input logic rd,
                                input logic [7:0] ad, input logic [15:0] wd);
      wr_en_i = wr;
      rd_en_i = rd;
      addr_i  = ad;
      wdata_i = wd;
   endtask

   // Advance to just after the next rising edge.
   task automatic stepClock();
      @(posedge clk_i);
      #1;
   endtask

   // One counted comparison.
   task automatic checkOutput(input string tag, input logic [15:0] obs,
                              input logic [15:0] expd);
      vectors++;
      assert (obs === expd) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%h, expected 0x%h (k=%0d)", tag, obs, expd, k);
      end
   endtask

   task automatic busWrite(input logic [7:0] ad, input logic [15:0] wd);
      applyStimulus(1'b1, 1'b0, ad, wd);
      stepClock();
      applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
   endtask

   task automatic busRead(input logic [7:0] ad, output logic [15:0] rd);
      applyStimulus(1'b0, 1'b1, ad, 16'h0000);
      stepClock();
      rd = rdata_o;
      applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
   endtask

   // Load the session's settings while disabled, let things settle, enable.
   task automatic startSession();
      busWrite(8'h00, 16'(sCenter << 1));
      busWrite(8'h01, 16'(sPsc));
      busWrite(8'h02, 16'(sPer));
      busWrite(8'h03, 16'(sDt));
      busWrite(8'h04, 16'(sMask));
      for (int ch = 0; ch < NCH; ch++) busWrite(8'(16 + ch), 16'(sDutyOld[ch]));
      for (int i = 0; i < 20; i++) stepClock();
      busWrite(8'h00, 16'((sCenter << 1) | 1));
      k = 0;
   endtask

   // Run the enabled session, applying scheduled writes and STATUS reads.
   task automatic runSession(input int nClk, input int rdEvery);
      for (int i = 0; i < nClk; i++) begin
         logic wr, rd;
         logic [7:0] ad;
         logic [15:0] wd;
         logic [NCH-1:0] ea, eb;
         wr = 1'b0; rd = 1'b0; ad = 8'h05; wd = 16'h0000;
         if (k + 1 == sKw) begin
            wr = 1'b1; ad = 8'(16 + sKwCh); wd = 16'(sDutyNew[sKwCh]);
         end else if (k + 1 == sKm) begin
            wr = 1'b1; ad = 8'h04; wd = 16'(sMaskNew);
         end else if (rdEvery > 0 && ((k + 1) % rdEvery) == 0) begin
            rd = 1'b1;
         end
         applyStimulus(wr, rd, ad, wd);
         stepClock();
         k++;
         expOut(k, ea, eb);
         checkOutput("pwm_a", 16'(pwm_a_o), 16'(ea));
         checkOutput("pwm_b", 16'(pwm_b_o), 16'(eb));
         checkOutput("period_evt", 16'(period_evt_o), 16'(expEvt(k)));
         if (rd) checkOutput("status", rdata_o, expStatus(k - 1));
      end
      applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
   endtask

   task automatic endSession();
      busWrite(8'h00, 16'h0000);
      stepClock();
   endtask

   task automatic clearSession();
      sPsc = 0; sPer = 9; sCenter = 0; sDt = 0;
      sKw = NEVER; sKwCh = 0; sKm = NEVER;
      sMask = '0; sMaskNew = '0;
      for (int ch = 0; ch < NCH; ch++) begin
         sDutyOld[ch] = 0;
         sDutyNew[ch] = 0;
      end
   endtask

   // Directed steps followed by randomized sessions.
   initial begin
      logic [15:0] rd;
      int runLen;

      // Reset state
      clearSession();
      repeat (3) stepClock();
      checkOutput("reset_a", 16'(pwm_a_o), 16'h0000);
      checkOutput("reset_b", 16'(pwm_b_o), 16'h0000);
      checkOutput("reset_rdata", rdata_o, 16'h0000);
      rst_n_i = 1'b1;
      stepClock();
      checkOutput("reset_evt", 16'(period_evt_o), 16'h0000);
      busRead(8'h05, rd); checkOutput("reset_status", rd, 16'h0000);
      busRead(8'h00, rd); checkOutput("reset_ctrl", rd, 16'h0000);
      busRead(8'h10, rd); checkOutput("reset_duty0", rd, 16'h0000);

      // Register readback, truncation, unmapped access
      busWrite(8'h01, 16'h1234); busRead(8'h01, rd); checkOutput("rb_psc", rd, 16'h0034);
      busWrite(8'h04, 16'hFFFF); busRead(8'h04, rd); checkOutput("rb_mask", rd, 16'h00FF);
      busWrite(8'h02, 16'hBEEF); busRead(8'h02, rd); checkOutput("rb_period", rd, 16'hBEEF);
      busWrite(8'h17, 16'h55AA); busRead(8'h17, rd); checkOutput("rb_duty7", rd, 16'h55AA);
      busWrite(8'h18, 16'h1111); busRead(8'h18, rd); checkOutput("rb_unmapped18", rd, 16'h0000);
      busRead(8'h06, rd); checkOutput("rb_unmapped06", rd, 16'h0000);
      busWrite(8'h03, 16'h0102); busRead(8'h03, rd);
`ifdef PWM_DEADTIME_EN
      checkOutput("rb_deadtime", rd, 16'h0002);
`else
      checkOutput("rb_deadtime", rd, 16'h0000);
`endif
      applyStimulus(1'b1, 1'b1, 8'h02, 16'h0042);
      stepClock();
      applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
      checkOutput("rd_wr_same_cycle", rdata_o, 16'hBEEF);
      stepClock();
      checkOutput("rdata_hold", rdata_o, 16'hBEEF);
      busRead(8'h02, rd); checkOutput("rb_period_new", rd, 16'h0042);

      // Edge mode with a mid-period duty change 3 -> 7
      clearSession();
      sMask = 8'h01; sDutyOld[0] = 3; sDutyNew[0] = 3;
      sKw = 14; sKwCh = 0; sDutyNew[0] = 7;
      startSession(); runSession(45, 7); endSession();

      // Center mode
      clearSession();
      sPsc = 1; sPer = 4; sCenter = 1; sMask = 8'h02;
      sDutyOld[1] = 2; sDutyNew[1] = 2;
      startSession(); runSession(50, 3); endSession();

      // Duty above PERIOD and duty zero
      clearSession();
      sMask = 8'h03; sDutyOld[0] = 12; sDutyNew[0] = 12;
      startSession(); runSession(25, 4); endSession();

      // Masking channel 0 while channel 1 keeps running
      clearSession();
      sMask = 8'h03; sMaskNew = 8'h02; sKm = 15;
      sDutyOld[0] = 3; sDutyNew[0] = 3; sDutyOld[1] = 5; sDutyNew[1] = 5;
      startSession(); runSession(35, 6); endSession();

      // Clearing EN mid-period
      clearSession();
      sMask = 8'h01; sDutyOld[0] = 4; sDutyNew[0] = 4;
      startSession(); runSession(14, 0);
      applyStimulus(1'b1, 1'b0, 8'h00, 16'h0000);
      stepClock();
      k++;
      applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
      checkOutput("dis_evt_at_write", 16'(period_evt_o), 16'(expEvt(k)));
      for (int i = 0; i < 12; i++) begin
         logic rdo;
         rdo = ((i % 3) == 1);
         applyStimulus(1'b0, rdo, 8'h05, 16'h0000);
         stepClock();
         checkOutput("dis_a", 16'(pwm_a_o), 16'h0000);
         checkOutput("dis_b", 16'(pwm_b_o), 16'h0000);
         checkOutput("dis_evt", 16'(period_evt_o), 16'h0000);
         if (rdo) checkOutput("dis_status", rdata_o, 16'h0000);
      end
      applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);

`ifdef PWM_DEADTIME_EN
      // Dead-time with a wide pulse, then a pulse shorter than the dead-time
      clearSession();
      sDt = 2; sMask = 8'h01; sDutyOld[0] = 5; sDutyNew[0] = 5;
      startSession(); runSession(30, 0); endSession();
      clearSession();
      sDt = 2; sMask = 8'h01; sDutyOld[0] = 1; sDutyNew[0] = 1;
      startSession(); runSession(25, 0); endSession();
`endif

      // Randomized sessions
      for (int s = 0; s < 8; s++) begin
         clearSession();
         sPsc    = int'($urandom_range(0, 2));
         sPer    = int'($urandom_range(0, 10));
         sCenter = int'($urandom_range(0, 1));
         sMask   = NCH'($urandom);
`ifdef PWM_DEADTIME_EN
         sDt     = int'($urandom_range(0, 3));
`endif
         for (int ch = 0; ch < NCH; ch++) begin
            sDutyOld[ch] = int'($urandom_range(0, sPer + 2));
            sDutyNew[ch] = sDutyOld[ch];
         end
         runLen = (sPsc + 1) * perLen() * 3 + 10;
         if (runLen > 200) runLen = 200;
         sKw   = int'($urandom_range(1, runLen - 1));
         sKwCh = int'($urandom_range(0, NCH - 1));
         sDutyNew[sKwCh] = int'($urandom_range(0, sPer + 2));
         if ($urandom_range(0, 1) == 1) begin
            sKm = int'($urandom_range(1, runLen - 1));
            sMaskNew = NCH'($urandom);
            if (sKm == sKw) sKm = NEVER;
         end
         startSession(); runSession(runLen, 5); endSession();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
